// File: rtl/axi_mover_pkg.sv
// Shared types and helpers for the burst mover: state encoding, the 4 KiB
// page size, beats-to-boundary arithmetic and the tail strobe mask.
package axi_mover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned Boundary4K   = 4096;
  localparam int unsigned MaxStrbWidth = 128;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;
  localparam logic [1:0]  AxiRespOkay  = 2'b00;

  // Whole beats left before the next 4 KiB page; offset is already beat aligned.
  function automatic logic [12:0] beats_to_boundary(input logic [11:0] offset,
                                                    input int unsigned shift);
    logic [12:0] bytes_left;
    bytes_left = 13'(Boundary4K) - {1'b0, offset};
    return bytes_left >> shift;
  endfunction

  // Byte-enable mask covering the low 'tail' bytes of a beat.
  function automatic logic [MaxStrbWidth-1:0] tail_strobe(input int unsigned tail);
    return (MaxStrbWidth'(1) << tail) - MaxStrbWidth'(1);
  endfunction

endpackage

// File: rtl/axi_burst_planner.sv
// Combinational burst sizer: the largest burst that respects the remaining
// beat count, the burst length cap and the 4 KiB pages on both sides.
module axi_burst_planner
  import axi_mover_pkg::*;
#(
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned AddrShift   = 3,
  parameter int unsigned MaxBurstLen = 256,
  parameter int unsigned BeatsWidth  = 9
) (
  input  logic [AddrWidth-1:0]  src,
  input  logic [AddrWidth-1:0]  dst,
  input  logic [AddrWidth-1:0]  remaining,
  output logic [BeatsWidth-1:0] beats
);

  logic [12:0]          src_room;
  logic [12:0]          dst_room;
  logic [AddrWidth-1:0] limit;
  logic                 unused_hi;

  // Only the page offset matters for boundary splitting.
  assign unused_hi = ^{src[AddrWidth-1:12], dst[AddrWidth-1:12]};

  // Take the minimum of the four limits.
  always_comb begin
    src_room = beats_to_boundary(src[11:0], AddrShift);
    dst_room = beats_to_boundary(dst[11:0], AddrShift);
    limit    = AddrWidth'(MaxBurstLen);
    if (AddrWidth'(src_room) < limit) limit = AddrWidth'(src_room);
    if (AddrWidth'(dst_room) < limit) limit = AddrWidth'(dst_room);
    if (remaining < limit) limit = remaining;
    beats = BeatsWidth'(limit);
  end

endmodule

// File: rtl/axi_burst_mover.sv
// Memory-to-memory AXI copy engine: issues paired AR/AW bursts split at
// 4 KiB pages, streams R straight into W, and tracks outstanding B responses.
module axi_burst_mover
  import axi_mover_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned MaxBurstLen    = 256,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // source host port (read side)
  output logic                   src_aw_valid,
  output logic [AddrWidth-1:0]   src_aw_addr,
  output logic [7:0]             src_aw_len,
  output logic [2:0]             src_aw_size,
  output logic [1:0]             src_aw_burst,
  output logic [IdWidth-1:0]     src_aw_id,
  output logic [3:0]             src_aw_cache,
  output logic [2:0]             src_aw_prot,
  output logic                   src_aw_lock,
  input  logic                   src_aw_ready,
  output logic                   src_w_valid,
  output logic [DataWidth-1:0]   src_w_data,
  output logic [DataWidth/8-1:0] src_w_strb,
  output logic                   src_w_last,
  input  logic                   src_w_ready,
  input  logic                   src_b_valid,
  input  logic [1:0]             src_b_resp,
  input  logic [IdWidth-1:0]     src_b_id,
  output logic                   src_b_ready,
  output logic                   src_ar_valid,
  output logic [AddrWidth-1:0]   src_ar_addr,
  output logic [7:0]             src_ar_len,
  output logic [2:0]             src_ar_size,
  output logic [1:0]             src_ar_burst,
  output logic [IdWidth-1:0]     src_ar_id,
  output logic [3:0]             src_ar_cache,
  output logic [2:0]             src_ar_prot,
  output logic                   src_ar_lock,
  input  logic                   src_ar_ready,
  input  logic                   src_r_valid,
  input  logic [DataWidth-1:0]   src_r_data,
  input  logic [1:0]             src_r_resp,
  input  logic                   src_r_last,
  input  logic [IdWidth-1:0]     src_r_id,
  output logic                   src_r_ready,
  // destination host port (write side)
  output logic                   dst_aw_valid,
  output logic [AddrWidth-1:0]   dst_aw_addr,
  output logic [7:0]             dst_aw_len,
  output logic [2:0]             dst_aw_size,
  output logic [1:0]             dst_aw_burst,
  output logic [IdWidth-1:0]     dst_aw_id,
  output logic [3:0]             dst_aw_cache,
  output logic [2:0]             dst_aw_prot,
  output logic                   dst_aw_lock,
  input  logic                   dst_aw_ready,
  output logic                   dst_w_valid,
  output logic [DataWidth-1:0]   dst_w_data,
  output logic [DataWidth/8-1:0] dst_w_strb,
  output logic                   dst_w_last,
  input  logic                   dst_w_ready,
  input  logic                   dst_b_valid,
  input  logic [1:0]             dst_b_resp,
  input  logic [IdWidth-1:0]     dst_b_id,
  output logic                   dst_b_ready,
  output logic                   dst_ar_valid,
  output logic [AddrWidth-1:0]   dst_ar_addr,
  output logic [7:0]             dst_ar_len,
  output logic [2:0]             dst_ar_size,
  output logic [1:0]             dst_ar_burst,
  output logic [IdWidth-1:0]     dst_ar_id,
  output logic [3:0]             dst_ar_cache,
  output logic [2:0]             dst_ar_prot,
  output logic                   dst_ar_lock,
  input  logic                   dst_ar_ready,
  input  logic                   dst_r_valid,
  input  logic [DataWidth-1:0]   dst_r_data,
  input  logic [1:0]             dst_r_resp,
  input  logic                   dst_r_last,
  input  logic [IdWidth-1:0]     dst_r_id,
  output logic                   dst_r_ready,
  // descriptor interface
  output logic                   ready_o,
  input  logic                   valid_i,
  input  logic [AddrWidth-1:0]   src_i,
  input  logic [AddrWidth-1:0]   dst_i,
  input  logic [AddrWidth-1:0]   len_i,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned Bytes      = DataWidth / 8;
  localparam int unsigned AddrShift  = $clog2(Bytes);
  localparam int unsigned BeatsWidth = $clog2(MaxBurstLen + 1);
  localparam int unsigned OutWidth   = $clog2(MaxOutstanding + 1);

  state_t                 state_reg, state_next;
  logic [AddrWidth-1:0]   src_addr_reg, dst_addr_reg, remaining_reg, w_left_reg;
  logic [AddrShift-1:0]   tail_reg;
  logic                   ar_done_reg, aw_done_reg, err_reg, done_reg, done_next;
  logic [OutWidth-1:0]    outstanding_reg, outstanding_next;
  logic [BeatsWidth-1:0]  burst_beats;
  logic [AddrWidth-1:0]   burst_bytes, total_beats;
  logic [Bytes-1:0]       strb_tail;
  logic                   idle, accept, issue_slot;
  logic                   ar_fire, aw_fire, pair_fire, b_fire, r_fire, w_fire;
  logic                   unused_ok;

  assign unused_ok = ^{src_aw_ready, src_w_ready, src_b_valid, src_b_resp, src_b_id,
                       src_r_id, dst_ar_ready, dst_r_valid, dst_r_data, dst_r_resp,
                       dst_r_last, dst_r_id, dst_b_id,
                       src_i[AddrShift-1:0], dst_i[AddrShift-1:0]};

  axi_burst_planner #(
    .AddrWidth  (AddrWidth),
    .AddrShift  (AddrShift),
    .MaxBurstLen(MaxBurstLen),
    .BeatsWidth (BeatsWidth)
  ) u_planner (
    .src      (src_addr_reg),
    .dst      (dst_addr_reg),
    .remaining(remaining_reg),
    .beats    (burst_beats)
  );

  assign idle        = (state_reg == ST_IDLE);
  assign accept      = idle && valid_i;
  assign issue_slot  = (state_reg == ST_ISSUE) && (outstanding_reg < OutWidth'(MaxOutstanding));
  assign ar_fire     = src_ar_valid && src_ar_ready;
  assign aw_fire     = dst_aw_valid && dst_aw_ready;
  assign pair_fire   = (state_reg == ST_ISSUE) && (ar_done_reg || ar_fire) && (aw_done_reg || aw_fire);
  assign b_fire      = dst_b_valid && dst_b_ready;
  assign r_fire      = src_r_valid && src_r_ready;
  assign w_fire      = dst_w_valid && dst_w_ready;
  assign burst_bytes = AddrWidth'(burst_beats) << AddrShift;
  assign total_beats = (len_i >> AddrShift) + AddrWidth'(|len_i[AddrShift-1:0]);

  // Next state, outstanding count and done pulse.
  always_comb begin
    state_next       = state_reg;
    outstanding_next = outstanding_reg;
    done_next        = 1'b0;
    case ({pair_fire, b_fire})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
    case (state_reg)
      ST_IDLE: begin
        if (valid_i) begin
          if (len_i == '0) done_next = 1'b1;
          else             state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (pair_fire && (remaining_reg == AddrWidth'(burst_beats))) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding_next == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control registers: FSM state, in-flight pair count, done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      outstanding_reg <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      done_reg        <= done_next;
    end
  end

  // Address/length bookkeeping and per-channel accepted flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_addr_reg  <= '0;
      dst_addr_reg  <= '0;
      remaining_reg <= '0;
      tail_reg      <= '0;
      ar_done_reg   <= 1'b0;
      aw_done_reg   <= 1'b0;
    end else if (accept) begin
      src_addr_reg  <= {src_i[AddrWidth-1:AddrShift], {AddrShift{1'b0}}};
      dst_addr_reg  <= {dst_i[AddrWidth-1:AddrShift], {AddrShift{1'b0}}};
      remaining_reg <= total_beats;
      tail_reg      <= len_i[AddrShift-1:0];
      ar_done_reg   <= 1'b0;
      aw_done_reg   <= 1'b0;
    end else if (pair_fire) begin
      src_addr_reg  <= src_addr_reg + burst_bytes;
      dst_addr_reg  <= dst_addr_reg + burst_bytes;
      remaining_reg <= remaining_reg - AddrWidth'(burst_beats);
      ar_done_reg   <= 1'b0;
      aw_done_reg   <= 1'b0;
    end else begin
      if (ar_fire) ar_done_reg <= 1'b1;
      if (aw_fire) aw_done_reg <= 1'b1;
    end
  end

  // W beat countdown for the tail strobe, and the sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_left_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) w_left_reg <= total_beats;
      else if (w_fire && (w_left_reg != '0)) w_left_reg <= w_left_reg - 1'b1;
      if (accept) err_reg <= 1'b0;
      else if ((r_fire && (src_r_resp != AxiRespOkay)) ||
               (b_fire && (dst_b_resp != AxiRespOkay))) err_reg <= 1'b1;
    end
  end

  // Final-beat strobe selection.
  always_comb begin
    strb_tail = Bytes'(tail_strobe(32'(tail_reg)));
    if ((w_left_reg == AddrWidth'(1)) && (tail_reg != '0)) dst_w_strb = strb_tail;
    else                                                    dst_w_strb = '1;
  end

  assign ready_o = idle;
  assign done_o  = done_reg;
  assign err_o   = err_reg;

  // Read address channel on the source port.
  assign src_ar_valid = issue_slot && !ar_done_reg;
  assign src_ar_addr  = src_addr_reg;
  assign src_ar_len   = 8'(burst_beats - 1'b1);
  assign src_ar_size  = 3'(AddrShift);
  assign src_ar_burst = AxiBurstIncr;
  assign src_ar_id    = '0;
  assign src_ar_cache = '0;
  assign src_ar_prot  = '0;
  assign src_ar_lock  = 1'b0;

  // Write address channel on the destination port, same burst as AR.
  assign dst_aw_valid = issue_slot && !aw_done_reg;
  assign dst_aw_addr  = dst_addr_reg;
  assign dst_aw_len   = 8'(burst_beats - 1'b1);
  assign dst_aw_size  = 3'(AddrShift);
  assign dst_aw_burst = AxiBurstIncr;
  assign dst_aw_id    = '0;
  assign dst_aw_cache = '0;
  assign dst_aw_prot  = '0;
  assign dst_aw_lock  = 1'b0;

  // R streams straight into W; nothing moves while idle.
  assign dst_w_valid = !idle && src_r_valid;
  assign src_r_ready = !idle && dst_w_ready;
  assign dst_w_data  = src_r_data;
  assign dst_w_last  = src_r_last;
  assign dst_b_ready = !idle;

  // Unused channels are tied off.
  assign src_aw_valid = 1'b0;
  assign src_aw_addr  = '0;
  assign src_aw_len   = '0;
  assign src_aw_size  = '0;
  assign src_aw_burst = '0;
  assign src_aw_id    = '0;
  assign src_aw_cache = '0;
  assign src_aw_prot  = '0;
  assign src_aw_lock  = 1'b0;
  assign src_w_valid  = 1'b0;
  assign src_w_data   = '0;
  assign src_w_strb   = '0;
  assign src_w_last   = 1'b0;
  assign src_b_ready  = 1'b0;
  assign dst_ar_valid = 1'b0;
  assign dst_ar_addr  = '0;
  assign dst_ar_len   = '0;
  assign dst_ar_size  = '0;
  assign dst_ar_burst = '0;
  assign dst_ar_id    = '0;
  assign dst_ar_cache = '0;
  assign dst_ar_prot  = '0;
  assign dst_ar_lock  = 1'b0;
  assign dst_r_ready  = 1'b0;

endmodule

// File: tb/tb_axi_burst_mover.sv
// Directed bench for the burst mover with simple AXI memory/sink models.
module tb_axi_burst_mover;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        src_aw_valid, src_aw_lock, src_w_valid, src_w_last, src_b_ready;
  logic [63:0] src_aw_addr, src_w_data, src_ar_addr, src_r_data;
  logic [7:0]  src_aw_len, src_w_strb, src_ar_len;
  logic [2:0]  src_aw_size, src_aw_prot, src_ar_size, src_ar_prot;
  logic [1:0]  src_aw_burst, src_ar_burst, src_b_resp, src_r_resp;
  logic [0:0]  src_aw_id, src_ar_id, src_b_id, src_r_id;
  logic [3:0]  src_aw_cache, src_ar_cache;
  logic        src_aw_ready, src_w_ready, src_b_valid, src_ar_valid, src_ar_lock, src_ar_ready;
  logic        src_r_valid, src_r_last, src_r_ready;
  logic        dst_aw_valid, dst_aw_lock, dst_w_valid, dst_w_last, dst_b_ready;
  logic [63:0] dst_aw_addr, dst_w_data, dst_ar_addr, dst_r_data;
  logic [7:0]  dst_aw_len, dst_w_strb, dst_ar_len;
  logic [2:0]  dst_aw_size, dst_aw_prot, dst_ar_size, dst_ar_prot;
  logic [1:0]  dst_aw_burst, dst_ar_burst, dst_b_resp, dst_r_resp;
  logic [0:0]  dst_aw_id, dst_ar_id, dst_b_id, dst_r_id;
  logic [3:0]  dst_aw_cache, dst_ar_cache;
  logic        dst_aw_ready, dst_w_ready, dst_b_valid, dst_ar_valid, dst_ar_lock, dst_ar_ready;
  logic        dst_r_valid, dst_r_last, dst_r_ready;
  logic        ready_o, valid_i, done_o, err_o;
  logic [63:0] src_i, dst_i, len_i;

  int n_cmp = 0;
  int n_bad = 0;

  // bus model state
  int          cyc = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0, wl_cnt = 0, b_cnt = 0;
  int          rb = 0, r_beat = 0, r_tot = 0, b_last_cyc = 0;
  logic [63:0] ar_addr_log[64];
  int          ar_len_log[64];
  int          ar_bcnt_log[64];
  logic [63:0] aw_addr_log[64];
  int          aw_len_log[64];
  logic [7:0]  w_strb_log[8192];
  logic        w_last_log[8192];
  logic [63:0] w_data_log[8192];
  bit          b_hold = 1'b0;
  int          b_err_idx = -1;
  int          r_err_idx = -1;
  logic [5:0]  rb_idx;

  assign rb_idx       = rb[5:0];
  assign src_aw_ready = 1'b0;
  assign src_w_ready  = 1'b0;
  assign src_b_valid  = 1'b0;
  assign src_b_resp   = 2'b00;
  assign src_b_id     = 1'b0;
  assign src_ar_ready = 1'b1;
  assign src_r_valid  = (rb < ar_cnt);
  assign src_r_data   = ar_addr_log[rb_idx] + 64'(r_beat) * 64'd8;
  assign src_r_last   = (r_beat == ar_len_log[rb_idx]);
  assign src_r_resp   = (r_tot == r_err_idx) ? 2'b10 : 2'b00;
  assign src_r_id     = 1'b0;
  assign dst_aw_ready = 1'b1;
  assign dst_w_ready  = 1'b1;
  assign dst_b_valid  = !b_hold && (((aw_cnt < wl_cnt) ? aw_cnt : wl_cnt) > b_cnt);
  assign dst_b_resp   = (b_cnt == b_err_idx) ? 2'b10 : 2'b00;
  assign dst_b_id     = 1'b0;
  assign dst_ar_ready = 1'b0;
  assign dst_r_valid  = 1'b0;
  assign dst_r_data   = 64'd0;
  assign dst_r_resp   = 2'b00;
  assign dst_r_last   = 1'b0;
  assign dst_r_id     = 1'b0;

  axi_burst_mover #(
    .AddrWidth(64), .DataWidth(64), .IdWidth(1), .MaxBurstLen(256), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .src_aw_valid(src_aw_valid), .src_aw_addr(src_aw_addr), .src_aw_len(src_aw_len),
    .src_aw_size(src_aw_size), .src_aw_burst(src_aw_burst), .src_aw_id(src_aw_id),
    .src_aw_cache(src_aw_cache), .src_aw_prot(src_aw_prot), .src_aw_lock(src_aw_lock),
    .src_aw_ready(src_aw_ready), .src_w_valid(src_w_valid), .src_w_data(src_w_data),
    .src_w_strb(src_w_strb), .src_w_last(src_w_last), .src_w_ready(src_w_ready),
    .src_b_valid(src_b_valid), .src_b_resp(src_b_resp), .src_b_id(src_b_id),
    .src_b_ready(src_b_ready), .src_ar_valid(src_ar_valid), .src_ar_addr(src_ar_addr),
    .src_ar_len(src_ar_len), .src_ar_size(src_ar_size), .src_ar_burst(src_ar_burst),
    .src_ar_id(src_ar_id), .src_ar_cache(src_ar_cache), .src_ar_prot(src_ar_prot),
    .src_ar_lock(src_ar_lock), .src_ar_ready(src_ar_ready), .src_r_valid(src_r_valid),
    .src_r_data(src_r_data), .src_r_resp(src_r_resp), .src_r_last(src_r_last),
    .src_r_id(src_r_id), .src_r_ready(src_r_ready),
    .dst_aw_valid(dst_aw_valid), .dst_aw_addr(dst_aw_addr), .dst_aw_len(dst_aw_len),
    .dst_aw_size(dst_aw_size), .dst_aw_burst(dst_aw_burst), .dst_aw_id(dst_aw_id),
    .dst_aw_cache(dst_aw_cache), .dst_aw_prot(dst_aw_prot), .dst_aw_lock(dst_aw_lock),
    .dst_aw_ready(dst_aw_ready), .dst_w_valid(dst_w_valid), .dst_w_data(dst_w_data),
    .dst_w_strb(dst_w_strb), .dst_w_last(dst_w_last), .dst_w_ready(dst_w_ready),
    .dst_b_valid(dst_b_valid), .dst_b_resp(dst_b_resp), .dst_b_id(dst_b_id),
    .dst_b_ready(dst_b_ready), .dst_ar_valid(dst_ar_valid), .dst_ar_addr(dst_ar_addr),
    .dst_ar_len(dst_ar_len), .dst_ar_size(dst_ar_size), .dst_ar_burst(dst_ar_burst),
    .dst_ar_id(dst_ar_id), .dst_ar_cache(dst_ar_cache), .dst_ar_prot(dst_ar_prot),
    .dst_ar_lock(dst_ar_lock), .dst_ar_ready(dst_ar_ready), .dst_r_valid(dst_r_valid),
    .dst_r_data(dst_r_data), .dst_r_resp(dst_r_resp), .dst_r_last(dst_r_last),
    .dst_r_id(dst_r_id), .dst_r_ready(dst_r_ready),
    .ready_o(ready_o), .valid_i(valid_i), .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
    .done_o(done_o), .err_o(err_o)
  );

  // Bus model: logs every handshake and walks the R/B responders.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_ar_valid && src_ar_ready) begin
      ar_addr_log[ar_cnt[5:0]] <= src_ar_addr;
      ar_len_log[ar_cnt[5:0]]  <= int'(src_ar_len);
      ar_bcnt_log[ar_cnt[5:0]] <= b_cnt;
      ar_cnt <= ar_cnt + 1;
    end
    if (dst_aw_valid && dst_aw_ready) begin
      aw_addr_log[aw_cnt[5:0]] <= dst_aw_addr;
      aw_len_log[aw_cnt[5:0]]  <= int'(dst_aw_len);
      aw_cnt <= aw_cnt + 1;
    end
    if (src_r_valid && src_r_ready) begin
      r_tot <= r_tot + 1;
      if (src_r_last) begin
        rb     <= rb + 1;
        r_beat <= 0;
      end else begin
        r_beat <= r_beat + 1;
      end
    end
    if (dst_w_valid && dst_w_ready) begin
      w_strb_log[w_cnt[12:0]] <= dst_w_strb;
      w_last_log[w_cnt[12:0]] <= dst_w_last;
      w_data_log[w_cnt[12:0]] <= dst_w_data;
      w_cnt <= w_cnt + 1;
      if (dst_w_last) wl_cnt <= wl_cnt + 1;
    end
    if (dst_b_valid && dst_b_ready) begin
      b_cnt      <= b_cnt + 1;
      b_last_cyc <= cyc;
    end
  end

  // Present one descriptor; returns at the negedge after it was accepted.
  task automatic start_desc(input logic [63:0] s, input logic [63:0] d,
                            input logic [63:0] l, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (ready_o !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) to = 1'b1;
    valid_i = 1'b1;
    src_i   = s;
    dst_i   = d;
    len_i   = l;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Wait (bounded) for done_o; reports the cycle stamp it was seen at.
  task automatic wait_done(output int dcyc, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (done_o !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (done_o !== 1'b1) to = 1'b1;
    dcyc = cyc;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b want=1", ready_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b want=0", done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b want=0", err_o); end
    n_cmp++; if ({src_ar_valid, dst_aw_valid, dst_w_valid, src_r_ready, dst_b_ready} !== 5'b0) begin
      n_bad++; $display("FAIL rst_handshakes got=%b want=00000",
                        {src_ar_valid, dst_aw_valid, dst_w_valid, src_r_ready, dst_b_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got=%b want=1", ready_o); end
    $display("test_reset done: %0d compared", n_cmp);
  endtask

  task automatic test_single;
    int a0, w0, b0, dc;
    bit to;
    a0 = ar_cnt; w0 = w_cnt; b0 = b_cnt;
    start_desc(64'h1000, 64'h2000, 64'd64, to);
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL single_busy_ready got=%b want=0", ready_o); end
    wait_done(dc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL single_done_timeout got=timeout want=done"); end
    n_cmp++; if (ar_cnt - a0 != 1) begin n_bad++; $display("FAIL single_ar_count got=%0d want=1", ar_cnt - a0); end
    n_cmp++; if (ar_addr_log[a0] !== 64'h1000 || ar_len_log[a0] != 7) begin
      n_bad++; $display("FAIL single_ar got=%h/%0d want=1000/7", ar_addr_log[a0], ar_len_log[a0]);
    end
    n_cmp++; if (aw_addr_log[a0] !== 64'h2000 || aw_len_log[a0] != 7) begin
      n_bad++; $display("FAIL single_aw got=%h/%0d want=2000/7", aw_addr_log[a0], aw_len_log[a0]);
    end
    n_cmp++; if (w_cnt - w0 != 8) begin n_bad++; $display("FAIL single_w_count got=%0d want=8", w_cnt - w0); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (w_strb_log[w0 + i] !== 8'hFF || w_last_log[w0 + i] !== (i == 7) ||
          w_data_log[w0 + i] !== 64'h1000 + 64'(8 * i)) begin
        n_bad++;
        $display("FAIL single_w_beat%0d got=%h/%b/%h want=ff/%b/%h", i, w_strb_log[w0 + i],
                 w_last_log[w0 + i], w_data_log[w0 + i], (i == 7), 64'h1000 + 64'(8 * i));
      end
    end
    n_cmp++; if (b_cnt - b0 != 1) begin n_bad++; $display("FAIL single_b_count got=%0d want=1", b_cnt - b0); end
    n_cmp++; if (dc != b_last_cyc + 1) begin n_bad++; $display("FAIL single_done_latency got=%0d want=%0d", dc, b_last_cyc + 1); end
    n_cmp++; if (err_o !== 1'b0 || ready_o !== 1'b1) begin n_bad++; $display("FAIL single_err_ready got=%b%b want=01", err_o, ready_o); end
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse got=%b want=0", done_o); end
    $display("test_single done: %0d compared", n_cmp);
  endtask

  task automatic test_multi_burst;
    int a0, w0, b0, dc;
    bit to;
    int exp_len[5] = '{255, 255, 255, 255, 1};
    a0 = ar_cnt; w0 = w_cnt; b0 = b_cnt;
    start_desc(64'h10000, 64'h20000, 64'h2010, to);
    wait_done(dc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL multi_done_timeout got=timeout want=done"); end
    n_cmp++; if (ar_cnt - a0 != 5) begin n_bad++; $display("FAIL multi_ar_count got=%0d want=5", ar_cnt - a0); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ar_addr_log[a0 + i] !== 64'h10000 + 64'(i * 'h800) || ar_len_log[a0 + i] != exp_len[i] ||
          aw_addr_log[a0 + i] !== 64'h20000 + 64'(i * 'h800) || aw_len_log[a0 + i] != exp_len[i]) begin
        n_bad++;
        $display("FAIL multi_burst%0d got=ar %h/%0d aw %h/%0d want=%h/%0d", i, ar_addr_log[a0 + i],
                 ar_len_log[a0 + i], aw_addr_log[a0 + i], aw_len_log[a0 + i],
                 64'h10000 + 64'(i * 'h800), exp_len[i]);
      end
    end
    n_cmp++; if (w_cnt - w0 != 1026) begin n_bad++; $display("FAIL multi_w_count got=%0d want=1026", w_cnt - w0); end
    n_cmp++; if (w_strb_log[w0 + 1025] !== 8'hFF || w_last_log[w0 + 1025] !== 1'b1) begin
      n_bad++; $display("FAIL multi_last_beat got=%h/%b want=ff/1", w_strb_log[w0 + 1025], w_last_log[w0 + 1025]);
    end
    n_cmp++; if (b_cnt - b0 != 5) begin n_bad++; $display("FAIL multi_b_count got=%0d want=5", b_cnt - b0); end
    $display("test_multi_burst done: %0d compared", n_cmp);
  endtask

  task automatic test_boundary;
    int a0, dc;
    bit to;
    a0 = ar_cnt;
    start_desc(64'h0FF0, 64'h5000, 64'd64, to);
    wait_done(dc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL bound_done_timeout got=timeout want=done"); end
    n_cmp++; if (ar_cnt - a0 != 2) begin n_bad++; $display("FAIL bound_ar_count got=%0d want=2", ar_cnt - a0); end
    n_cmp++; if (ar_addr_log[a0] !== 64'h0FF0 || ar_len_log[a0] != 1 || aw_addr_log[a0] !== 64'h5000 || aw_len_log[a0] != 1) begin
      n_bad++; $display("FAIL bound_burst1 got=ar %h/%0d aw %h/%0d want=ff0/1 5000/1",
                        ar_addr_log[a0], ar_len_log[a0], aw_addr_log[a0], aw_len_log[a0]);
    end
    n_cmp++; if (ar_addr_log[a0 + 1] !== 64'h1000 || ar_len_log[a0 + 1] != 5 || aw_addr_log[a0 + 1] !== 64'h5010 || aw_len_log[a0 + 1] != 5) begin
      n_bad++; $display("FAIL bound_burst2 got=ar %h/%0d aw %h/%0d want=1000/5 5010/5",
                        ar_addr_log[a0 + 1], ar_len_log[a0 + 1], aw_addr_log[a0 + 1], aw_len_log[a0 + 1]);
    end
    $display("test_boundary done: %0d compared", n_cmp);
  endtask

  task automatic test_tail_and_zero;
    int a0, aw0, w0, dc;
    bit to;
    a0 = ar_cnt; w0 = w_cnt;
    start_desc(64'h3000, 64'h4000, 64'd13, to);
    wait_done(dc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL tail_done_timeout got=timeout want=done"); end
    n_cmp++; if (ar_len_log[a0] != 1 || aw_len_log[a0] != 1) begin
      n_bad++; $display("FAIL tail_len got=%0d/%0d want=1/1", ar_len_log[a0], aw_len_log[a0]);
    end
    n_cmp++; if (w_strb_log[w0] !== 8'hFF) begin n_bad++; $display("FAIL tail_strb1 got=%h want=ff", w_strb_log[w0]); end
    n_cmp++; if (w_strb_log[w0 + 1] !== 8'h1F || w_last_log[w0 + 1] !== 1'b1) begin
      n_bad++; $display("FAIL tail_strb2 got=%h/%b want=1f/1", w_strb_log[w0 + 1], w_last_log[w0 + 1]);
    end
    a0 = ar_cnt; aw0 = aw_cnt;
    @(negedge clk);
    start_desc(64'h7000, 64'h8000, 64'd0, to);
    n_cmp++; if (done_o !== 1'b1 || ready_o !== 1'b1) begin
      n_bad++; $display("FAIL zero_done got=%b%b want=11", done_o, ready_o);
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (ar_cnt != a0 || aw_cnt != aw0 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL zero_no_traffic got=ar+%0d aw+%0d done=%b want=0 0 0", ar_cnt - a0, aw_cnt - aw0, done_o);
    end
    $display("test_tail_and_zero done: %0d compared", n_cmp);
  endtask

  task automatic test_outstanding;
    int a0, aw0, b0, wl0, n, dc;
    bit to;
    a0 = ar_cnt; aw0 = aw_cnt; b0 = b_cnt; wl0 = wl_cnt;
    b_hold = 1'b1;
    start_desc(64'h80000, 64'h90000, 64'd16384, to);
    n = 0;
    while (wl_cnt - wl0 < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    n_cmp++; if (ar_cnt - a0 != 4 || aw_cnt - aw0 != 4) begin
      n_bad++; $display("FAIL out_limit got=ar %0d aw %0d want=4 4", ar_cnt - a0, aw_cnt - aw0);
    end
    n_cmp++; if (src_ar_valid !== 1'b0 || dst_aw_valid !== 1'b0) begin
      n_bad++; $display("FAIL out_valids_low got=%b%b want=00", src_ar_valid, dst_aw_valid);
    end
    b_hold = 1'b0;
    wait_done(dc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL out_done_timeout got=timeout want=done"); end
    n_cmp++; if (ar_cnt - a0 != 8 || b_cnt - b0 != 8) begin
      n_bad++; $display("FAIL out_totals got=ar %0d b %0d want=8 8", ar_cnt - a0, b_cnt - b0);
    end
    n_cmp++; if (ar_bcnt_log[a0 + 4] <= b0) begin
      n_bad++; $display("FAIL out_fifth_after_b got=b_seen %0d want=>%0d", ar_bcnt_log[a0 + 4], b0);
    end
    $display("test_outstanding done: %0d compared", n_cmp);
  endtask

  task automatic test_error;
    int a0, b0, dc;
    bit to;
    a0 = ar_cnt; b0 = b_cnt;
    b_err_idx = b_cnt + 1;
    start_desc(64'h30000, 64'h40000, 64'd6144, to);
    wait_done(dc, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL err_done_timeout got=timeout want=done"); end
    n_cmp++; if (ar_cnt - a0 != 3 || b_cnt - b0 != 3) begin
      n_bad++; $display("FAIL err_bursts got=ar %0d b %0d want=3 3", ar_cnt - a0, b_cnt - b0);
    end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_bresp got=%b want=1", err_o); end
    b_err_idx = -1;
    repeat (3) @(negedge clk);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=1", err_o); end
    start_desc(64'h50000, 64'h60000, 64'd8, to);
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b want=0", err_o); end
    wait_done(dc, to);
    n_cmp++; if (to || err_o !== 1'b0) begin n_bad++; $display("FAIL err_clean_run got=to%b err%b want=0 0", to, err_o); end
    @(negedge clk);
    r_err_idx = r_tot + 1;
    start_desc(64'h51000, 64'h61000, 64'd16, to);
    wait_done(dc, to);
    r_err_idx = -1;
    n_cmp++; if (to || err_o !== 1'b1) begin n_bad++; $display("FAIL err_rresp got=to%b err%b want=0 1", to, err_o); end
    $display("test_error done: %0d compared", n_cmp);
  endtask

  initial begin
    valid_i = 1'b0;
    src_i   = '0;
    dst_i   = '0;
    len_i   = '0;
    test_reset();
    test_single();
    test_multi_burst();
    test_boundary();
    test_tail_and_zero();
    test_outstanding();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
